// File: rtl/lsu_dmem_port.sv
// Load/store unit: one outstanding access on a grant/read-valid data-memory port.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module lsu_dmem_port #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  input  logic [2:0]  MemRead,
  input  logic [2:0]  MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  input  logic [4:0]  Rd,
  output logic        Stall,
  output logic        LoadValid,
  output logic [31:0] LoadData,
  output logic [4:0]  LoadRd,
  output logic        BusErr,
  output logic        MisalignErr,
  output logic        DmemReq,
  output logic        DmemWe,
  output logic [31:0] DmemAddr,
  output logic [3:0]  DmemBe,
  output logic [31:0] DmemWData,
  input  logic        DmemGnt,
  input  logic        DmemRValid,
  input  logic [31:0] DmemRData
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  function automatic logic code_legal(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b011) || (c == 3'b111);
  endfunction

  function automatic size_e code_size(input logic [2:0] c);
    return (c == 3'b001) ? SZ_B : (c == 3'b011) ? SZ_H : SZ_W;
  endfunction

  state_e      state, state_d;
  logic        is_store, mem_op;
  size_e       op_size;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        issue, grant, timeout, rtake;
  logic        st_is_store;
  size_e       ld_size;
  logic [1:0]  ld_lo;
  logic [7:0]  cnt;
  logic        cnt_hit;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Store wins when both codes are legal in the same cycle.
  assign is_store = code_legal(MemWrite);
  assign mem_op   = ReqValid && (code_legal(MemRead) || is_store);
  assign op_size  = is_store ? code_size(MemWrite) : code_size(MemRead);
  assign cnt_hit  = (cnt == 8'(TIMEOUT_CYC - 1));
  assign Stall    = ((state == IDLE) && mem_op) || (state == REQ) || (state == WAIT_R);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign, trap;
  assign misalign = ((op_size == SZ_H) && Addr[0]) ||
                    ((op_size == SZ_W) && (Addr[1:0] != 2'b00));
`endif

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = StoreData;
    unique case (op_size)
      SZ_B: begin
        be_d    = 4'b0001 << Addr[1:0];
        wdata_d = {4{StoreData[7:0]}};
      end
      SZ_H: begin
        be_d    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = DmemRData[7:0];
    case (ld_lo)
      2'd1:    ld_byte = DmemRData[15:8];
      2'd2:    ld_byte = DmemRData[23:16];
      2'd3:    ld_byte = DmemRData[31:24];
      default: ;
    endcase
    ld_half = ld_lo[1] ? DmemRData[31:16] : DmemRData[15:0];
    unique case (ld_size)
      SZ_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      default: ld_ext = DmemRData;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state;
    issue   = 1'b0;
    grant   = 1'b0;
    timeout = 1'b0;
    rtake   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap    = 1'b0;
`endif
    unique case (state)
      IDLE: if (mem_op) begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (misalign) begin
          trap    = 1'b1;
          state_d = RESP;
        end else
`endif
        begin
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: if (DmemGnt) begin
        grant   = 1'b1;
        state_d = st_is_store ? RESP : WAIT_R;
      end else if (cnt_hit) begin
        timeout = 1'b1;
        state_d = RESP;
      end
      WAIT_R: if (DmemRValid) begin
        rtake   = 1'b1;
        state_d = RESP;
      end else if (cnt_hit) begin
        timeout = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, because every bus/load output must read 0 out of reset.
    if (!rst_n) begin
      DmemReq     <= 1'b0;
      DmemWe      <= 1'b0;
      DmemAddr    <= '0;
      DmemBe      <= '0;
      DmemWData   <= '0;
      LoadValid   <= 1'b0;
      LoadData    <= '0;
      LoadRd      <= '0;
      BusErr      <= 1'b0;
      st_is_store <= 1'b0;
      ld_size     <= SZ_B;
      ld_lo       <= '0;
      cnt         <= '0;
    end else begin
      LoadValid <= rtake;
      BusErr    <= timeout;
      if (issue) begin
        DmemReq     <= 1'b1;
        DmemWe      <= is_store;
        DmemAddr    <= {Addr[31:2], 2'b00};
        DmemBe      <= be_d;
        DmemWData   <= wdata_d;
        st_is_store <= is_store;
        ld_size     <= op_size;
        ld_lo       <= Addr[1:0];
        if (!is_store) LoadRd <= Rd;
      end
      if (grant || timeout) DmemReq <= 1'b0;
      // Counter restarts on entry to REQ (issue) and to WAIT_R (grant).
      if (issue || grant)                          cnt <= '0;
      else if ((state == REQ) || (state == WAIT_R)) cnt <= cnt + 8'd1;
      if (rtake) LoadData <= ld_ext;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) MisalignErr <= 1'b0;
    else        MisalignErr <= trap;
  end
`else
  assign MisalignErr = 1'b0;
`endif

endmodule

// File: doc/lsu_dmem_port.md
# lsu_dmem_port

Load/store unit sitting directly downstream of the main decoder/execute stage. It consumes the 3-bit MemRead/MemWrite size codes (001 byte, 011 half, 111 word) together with the ALU-computed address and rs2 data. It runs a single outstanding transaction on a grant/read-valid data-memory port, aligns byte lanes, and sign-extends load data. The pipeline is stalled until each transaction completes.

## Interface
- TIMEOUT_CYC, 255: cycles waited in REQ or WAIT_R before abort; legal range 1–255, counter 8 bits
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ReqValid  in  1  execute stage holds a valid instruction
- MemRead  in  3  load size code
- MemWrite  in  3  store size code
- Addr  in  32  effective byte address
- StoreData  in  32  rs2 value
- Rd  in  5  load destination register
- Stall  out  1  freeze upstream stages
- LoadValid  out  1  one-cycle pulse, LoadData/LoadRd valid
- LoadData  out  32  sign-extended load result
- LoadRd  out  5  destination of LoadData
- BusErr  out  1  one-cycle pulse, timeout abort
- MisalignErr  out  1  one-cycle pulse, misaligned access (constant 0 when macro absent)
- DmemReq  out  1  request, held until granted
- DmemWe  out  1  1 = write
- DmemAddr  out  32  word address, bits [1:0] = 00
- DmemBe  out  4  byte enables
- DmemWData  out  32  lane-replicated store data
- DmemGnt  in  1  request accepted at this edge
- DmemRValid  in  1  read data valid
- DmemRData  in  32  read word

## Operation
- Legal codes: 001, 011, 111. Any other value (incl. 000, X) is no-op. MemOp = ReqValid & (legal MemRead | legal MemWrite).
- Both MemRead and MemWrite legal in the same cycle: store wins.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE, MemOp=1: register op, size, Addr, StoreData, Rd; go to REQ (or RESP on misalign trap).
- REQ: DmemReq=1. On DmemGnt: store goes to RESP, load goes to WAIT_R.
- WAIT_R: on DmemRValid, capture the extracted lane into LoadData; go to RESP.
- RESP: one cycle. Pulse LoadValid (load success), BusErr or MisalignErr; then IDLE. ReqValid is ignored in RESP.
- Stall = (IDLE & MemOp) | REQ | WAIT_R. Stall is 0 in RESP, so upstream advances at the RESP edge.
- Byte enables by size:
  - byte: Be = 0001 << Addr[1:0], WData = {4{StoreData[7:0]}}
  - half: Be = 0011 << {Addr[1],0}, WData = {2{StoreData[15:0]}}
  - word: Be = 1111, WData = StoreData
- DmemAddr = {Addr[31:2], 2'b00}. DmemWe and DmemBe are driven for loads too (We=0).
- Load extract: select the byte or half by Addr, sign-extend from bit 7 or 15.
- Timeout: an 8-bit counter clears on entry to REQ and to WAIT_R and increments each cycle there. On reaching TIMEOUT_CYC: drop DmemReq, go to RESP with BusErr=1, LoadValid=0.
- DmemRValid outside WAIT_R is ignored, including a late response after a timeout.

## Timing
- All outputs except Stall are registered. Stall is combinational from state, ReqValid and codes.
- Reset: state=IDLE. Every output is 0: Stall=0 when ReqValid=0, DmemAddr/DmemBe/DmemWData/LoadData/LoadRd all 0.
- Reset mid-transaction: DmemReq drops immediately (asynchronously) and the in-flight op is discarded.
- Bus protocol: Req, We, Addr, Be and WData stay stable while Req=1 & Gnt=0. DmemRValid arrives at least one cycle after the grant edge.
- Minimum store: issue cycle T (IDLE), REQ at T+1 with Gnt, RESP at T+2. Stall is high for 2 cycles.
- Minimum load: T IDLE, T+1 REQ/Gnt, T+2 WAIT_R/RValid, T+3 RESP with LoadValid. Stall is high for 3 cycles.
- Back-to-back ops: the next instruction is seen in IDLE the cycle after RESP.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A half with Addr[0]=1, or a word with Addr[1:0]≠0, goes IDLE→RESP directly.
  - MisalignErr=1 for one cycle; no DmemReq; Stall high one cycle.
- LSU_MISALIGN_TRAP_EN undefined:
  - Offending low address bits are ignored (half uses Addr[1] only, word uses all lanes).
  - The access proceeds normally; MisalignErr is tied 0.

## Test plan
- Word store, Addr=0x1000_0006, MemWrite=111, StoreData=0xDEAD_BEEF, Gnt immediate -> trapped build: MisalignErr pulse, no DmemReq. Untrapped build: DmemAddr=0x1000_0004, Be=1111, WData=0xDEAD_BEEF, Stall 2 cycles.
- Byte load, Addr=0x0000_0203, MemRead=001, Rd=5, Gnt immediate, RData=0x80FF_1234 one cycle later -> LoadData=0xFFFF_FF80, LoadRd=5, LoadValid at T+3.
- Half store, Addr=0x0000_0012, StoreData=0x0000_A55A, Gnt delayed 4 cycles -> Be=1100, WData=0xA55A_A55A, signals stable across all 4 wait cycles.
- Load with TIMEOUT_CYC=8, Gnt never asserted -> DmemReq drops after 8 REQ cycles, BusErr pulse, LoadValid=0. A later RValid is ignored.
- MemRead=011 and MemWrite=111 together at Addr=0x40 -> a word write is issued, no read.
- rst_n asserted during WAIT_R -> DmemReq=0 and Stall=0 immediately; after release, a fresh load completes normally.
